// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchronised serial input, 16x oversampled mid-bit sampling,
// 8 data bits LSB first, optional even parity, one stop bit, byte delivered with a one-clk strobe.
module uart_receiver #(
    parameter int unsigned CLOCK_RATE = 10000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_enable,
    input  logic       parity_enable,
    input  logic       rx_data_in,
    output logic [7:0] rx_data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       busy
);

    localparam int unsigned DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SAMP_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned MID     = (OVERSAMPLE >= 2) ? (OVERSAMPLE / 2 - 1) : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_sync;
    logic                r_rx_prev;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [SAMP_W-1:0]   r_samp_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_par_en;
    logic                r_perr;
    logic [7:0]          r_data_out;
    logic                r_data_valid;
    logic                r_parity_error;
    logic                r_framing_error;
    logic                r_busy;

    logic                w_rx_s;
    logic                w_fall;
    logic                w_start;
    logic                w_tick;
    logic                w_mid;
    logic                w_frame_done;

    assign w_rx_s       = r_sync[1];
    assign w_fall       = r_rx_prev & ~w_rx_s;
    assign w_start      = (r_state == S_IDLE) && rx_enable && w_fall;
    assign w_tick       = (r_state != S_IDLE) && (r_tick_cnt == TICK_W'(DIV - 1));
    assign w_mid        = w_tick && (r_samp_cnt == SAMP_W'(MID));
    assign w_frame_done = (r_state == S_STOP) && w_mid && rx_enable;

    // Input synchroniser plus one more stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx_data_in};
            r_rx_prev <= w_rx_s;
        end
    end

    // Baud tick and oversample counters, held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_samp_cnt <= (r_samp_cnt == SAMP_W'(OVERSAMPLE - 1)) ? '0 : r_samp_cnt + 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!rx_enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_fall) w_state_next = S_START;
                S_START:  if (w_mid) w_state_next = w_rx_s ? S_IDLE : S_DATA;
                S_DATA:   if (w_mid && (r_bit_cnt == 3'd7))
                              w_state_next = r_par_en ? S_PARITY : S_STOP;
                S_PARITY: if (w_mid) w_state_next = S_STOP;
                S_STOP:   if (w_mid) w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Frame datapath: parity mode latched at start, data shifted in LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_perr    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_bit_cnt <= '0;
            r_perr    <= 1'b0;
            if (w_start) r_par_en <= parity_enable;
        end else if (w_mid) begin
            case (r_state)
                S_DATA: begin
                    r_shift   <= {w_rx_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                S_PARITY: r_perr <= w_rx_s ^ (^r_shift);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out      <= '0;
            r_data_valid    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_data_valid <= w_frame_done;
            r_busy       <= (w_state_next != S_IDLE);
            if (w_frame_done) begin
                r_data_out      <= r_shift;
                r_framing_error <= ~w_rx_s;
                r_parity_error  <= r_par_en & r_perr;
            end
        end
    end

    assign rx_data_out   = r_data_out;
    assign data_valid    = r_data_valid;
    assign parity_error  = r_parity_error;
    assign framing_error = r_framing_error;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: fast config (16 clk/bit) for directed vectors and
// corner cases, plus a default-config instance fed at the true 10 MHz / 9600 bit period.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_enable;
    logic       parity_enable;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] a_data;
    logic       a_valid, a_perr, a_ferr, a_busy;
    logic [7:0] b_data;
    logic       b_valid, b_perr, b_ferr, b_busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         valid_cnt = 0;
    int         busy_cnt = 0;
    int         b_valid_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] b_last = 8'h00;

    always #5 clk = ~clk;

    uart_receiver #(.CLOCK_RATE(1600), .BAUD_RATE(100), .OVERSAMPLE(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .parity_enable(parity_enable),
        .rx_data_in(rx_a), .rx_data_out(a_data), .data_valid(a_valid),
        .parity_error(a_perr), .framing_error(a_ferr), .busy(a_busy)
    );

    uart_receiver u_e2e (
        .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .parity_enable(parity_enable),
        .rx_data_in(rx_b), .rx_data_out(b_data), .data_valid(b_valid),
        .parity_error(b_perr), .framing_error(b_ferr), .busy(b_busy)
    );

    // Counts strobe cycles, so a strobe longer than one clk shows up as an extra count.
    always @(negedge clk) begin
        if (a_valid) begin
            valid_cnt++;
            rxq.push_back(a_data);
        end
        if (a_busy) busy_cnt++;
        if (b_valid) begin
            b_valid_cnt++;
            b_last = b_data;
        end
    end

    typedef struct {
        logic [7:0] data;
        bit         use_par;
        bit         par_bit;
        bit         exp_perr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_a = b;
        wait_clks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit use_par, input bit par_bit,
                              input bit stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    int         base;
    int         bbase;
    logic [7:0] last_exp;
    logic [7:0] e2e_byte;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h7A, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h7A, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx_enable = 1'b0;
        parity_enable = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        wait_clks(3);
        check("reset_data", a_data, 8'h00);
        check("reset_valid", a_valid, 1'b0);
        check("reset_perr", a_perr, 1'b0);
        check("reset_ferr", a_ferr, 1'b0);
        check("reset_busy", a_busy, 1'b0);
        rst_n = 1'b1;
        rx_enable = 1'b1;
        wait_clks(5);

        // Directed frame table.
        foreach (vecs[k]) begin
            base = valid_cnt;
            parity_enable = vecs[k].use_par;
            send_frame(vecs[k].data, vecs[k].use_par, vecs[k].par_bit, 1'b1);
            wait_clks(6);
            check($sformatf("vec%0d_count", k), 32'(valid_cnt - base), 32'd1);
            check($sformatf("vec%0d_data", k), a_data, vecs[k].data);
            check($sformatf("vec%0d_perr", k), a_perr, vecs[k].exp_perr);
            check($sformatf("vec%0d_ferr", k), a_ferr, 1'b0);
            check($sformatf("vec%0d_busy", k), a_busy, 1'b0);
        end
        parity_enable = 1'b0;

        // Framing error, then line held low must not retrigger.
        base = valid_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clks(3);
        check("ferr_count", 32'(valid_cnt - base), 32'd1);
        check("ferr_data", a_data, 8'h3C);
        check("ferr_flag", a_ferr, 1'b1);
        check("ferr_perr", a_perr, 1'b0);
        base = busy_cnt;
        wait_clks(60);
        check("low_line_no_retrigger", 32'(busy_cnt - base), 32'd0);
        rx_a = 1'b1;
        wait_clks(20);
        base = valid_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        wait_clks(6);
        check("after_low_count", 32'(valid_cnt - base), 32'd1);
        check("after_low_data", a_data, 8'h81);
        check("after_low_ferr", a_ferr, 1'b0);
        last_exp = 8'h81;

        // Three-clk glitch on idle line: busy pulses, no byte.
        base = valid_cnt;
        bbase = busy_cnt;
        rx_a = 1'b0;
        wait_clks(3);
        rx_a = 1'b1;
        wait_clks(30);
        check("glitch_busy_seen", 32'(busy_cnt - bbase > 0), 32'd1);
        check("glitch_busy_low", a_busy, 1'b0);
        check("glitch_no_valid", 32'(valid_cnt - base), 32'd0);

        // Abort during bit 4 of 8'hFF.
        base = valid_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_a = 1'b1;
        wait_clks(8);
        check("abort_busy_before", a_busy, 1'b1);
        rx_enable = 1'b0;
        wait_clks(1);
        check("abort_idle_next_clk", a_busy, 1'b0);
        wait_clks(100);
        check("abort_no_valid", 32'(valid_cnt - base), 32'd0);
        check("abort_data_held", a_data, last_exp);
        rx_enable = 1'b1;
        wait_clks(5);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        wait_clks(6);
        check("abort_then_count", 32'(valid_cnt - base), 32'd1);
        check("abort_then_data", a_data, 8'h01);

        // Back-to-back frames with no idle gap.
        base = rxq.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        wait_clks(6);
        check("b2b_count", 32'(rxq.size() - base), 32'd2);
        check("b2b_first", rxq[base], 8'h55);
        check("b2b_second", rxq[base+1], 8'hAA);
        check("b2b_perr", a_perr, 1'b0);
        check("b2b_ferr", a_ferr, 1'b0);

        // Default-config instance fed at the real 10 MHz / 9600 bit period (~1042 clk/bit).
        e2e_byte = 8'hC3;
        bbase = b_valid_cnt;
        rx_b = 1'b0;
        wait_clks(1042);
        for (int i = 0; i < 8; i++) begin
            rx_b = e2e_byte[i];
            wait_clks(1042);
        end
        rx_b = 1'b1;
        wait_clks(1100);
        check("e2e_count", 32'(b_valid_cnt - bbase), 32'd1);
        check("e2e_data", b_last, 8'hC3);
        check("e2e_perr", b_perr, 1'b0);
        check("e2e_ferr", b_ferr, 1'b0);
        check("e2e_busy", b_busy, 1'b0);

        // Reset asserted mid-frame.
        base = valid_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx_a = 1'b0;
        wait_clks(5);
        rst_n = 1'b0;
        #1;
        check("midrst_data", a_data, 8'h00);
        check("midrst_valid", a_valid, 1'b0);
        check("midrst_perr", a_perr, 1'b0);
        check("midrst_ferr", a_ferr, 1'b0);
        check("midrst_busy", a_busy, 1'b0);
        rx_a = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(40);
        check("midrst_quiet_busy", a_busy, 1'b0);
        check("midrst_no_valid", 32'(valid_cnt - base), 32'd0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1);
        wait_clks(6);
        check("midrst_recover_data", a_data, 8'h96);
        check("midrst_recover_count", 32'(valid_cnt - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
